// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and helpers for the FIFO-fed UART transmitter
package uart_pkg;
  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } par_mode_e;
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2, ST_BREAK
  } state_e;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic [3:0] MIN_CHAR = 4'd5;
  function automatic logic [3:0] eff_size(input logic [3:0] cs, input logic [3:0] max_c);
    return cs < MIN_CHAR ? MIN_CHAR : (cs > max_c ? max_c : cs);
  endfunction
endpackage

// File: rtl/uart_tx_fifo_ctrl_fifo.sv
// uart_tx_fifo: circular-buffer TX FIFO with wrapping pointers and occupancy count
import uart_pkg::*;
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(DEPTH);
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = do_push ? wr_q + AW'(1) : wr_q;
    rd_d = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: FIFO-fed UART transmitter with parity, 1/2 stop bits and break
import uart_pkg::*;
module uart_tx_fifo_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_CHAR = 9
) (
  input  logic                              baud,
  input  logic                              rst,
  input  logic                              te,
  input  logic [MAX_CHAR-1:0]               data_in,
  input  logic                              data_valid,
  output logic                              data_ready,
  input  logic [3:0]                        char_size,
  input  logic [1:0]                        parity_mode,
  input  logic                              stop2,
  input  logic                              send_break,
  output logic                              tx,
  output logic                              tx_busy,
  output logic                              txc,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  localparam logic [3:0] MAXC = 4'(MAX_CHAR);
  state_e state_q, state_d;
  logic tx_q, tx_d, busy_q, busy_d, txc_q, txc_d, brk_rel_q, brk_rel_d;
  logic par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
  logic [MAX_CHAR-1:0] shr_q, shr_d, rdata, masked;
  logic [3:0] n_q, n_d, cnt_q, cnt_d, n_new;
  logic push, pop, empty, full, frame_end, go;
  assign data_ready = !full;
  assign push = data_valid && !full;
  assign tx = tx_q;
  assign tx_busy = busy_q;
  assign txc = txc_q;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(MAX_CHAR)) u_fifo (
    .clk(baud), .rst(rst), .push(push), .pop(pop), .wdata(data_in),
    .rdata(rdata), .count(fifo_count), .empty(empty), .full(full)
  );
  always_comb begin
    n_new = eff_size(char_size, MAXC);
    masked = '0;
    for (int i = 0; i < MAX_CHAR; i++) masked[i] = rdata[i] && (i < int'(n_new));
  end
  always_comb begin
    state_d = state_q;
    tx_d = tx_q;
    busy_d = busy_q;
    txc_d = 1'b0;
    brk_rel_d = brk_rel_q;
    shr_d = shr_q;
    n_d = n_q;
    cnt_d = cnt_q;
    par_en_d = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d = stop2_q;
    pop = 1'b0;
    frame_end = (state_q == ST_STOP1 && !stop2_q) || state_q == ST_STOP2;
    go = (state_q == ST_IDLE || frame_end) && !send_break && te && !empty;
    case (state_q)
      ST_IDLE: if (send_break) begin
        state_d = ST_BREAK;
        tx_d = LINE_START;
        busy_d = 1'b1;
        brk_rel_d = 1'b0;
      end
      ST_START: begin
        state_d = ST_DATA;
        tx_d = shr_q[0];
        shr_d = shr_q >> 1;
        cnt_d = 4'd1;
      end
      ST_DATA: if (cnt_q == n_q) begin
        state_d = par_en_q ? ST_PARITY : ST_STOP1;
        tx_d = par_en_q ? par_bit_q : LINE_IDLE;
      end else begin
        tx_d = shr_q[0];
        shr_d = shr_q >> 1;
        cnt_d = cnt_q + 4'd1;
      end
      ST_PARITY: begin
        state_d = ST_STOP1;
        tx_d = LINE_IDLE;
      end
      ST_STOP1: if (stop2_q) begin
        state_d = ST_STOP2;
        tx_d = LINE_IDLE;
      end
      // after release the line spends one idle-level cycle still flagged busy
      ST_BREAK: if (brk_rel_q) begin
        state_d = ST_IDLE;
        tx_d = LINE_IDLE;
        busy_d = 1'b0;
      end else if (!send_break) begin
        brk_rel_d = 1'b1;
        tx_d = LINE_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (frame_end) begin
      state_d = ST_IDLE;
      tx_d = LINE_IDLE;
      busy_d = 1'b0;
      txc_d = empty;
    end
    if (go) begin
      pop = 1'b1;
      state_d = ST_START;
      tx_d = LINE_START;
      busy_d = 1'b1;
      shr_d = masked;
      n_d = n_new;
      par_en_d = parity_mode == PAR_EVEN || parity_mode == PAR_ODD;
      par_bit_d = (^masked) ^ (parity_mode == PAR_ODD);
      stop2_d = stop2;
    end
  end
  always_ff @(posedge baud) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tx_q <= LINE_IDLE;
      busy_q <= 1'b0;
      txc_q <= 1'b0;
      brk_rel_q <= 1'b0;
      shr_q <= '0;
      n_q <= MIN_CHAR;
      cnt_q <= '0;
      par_en_q <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      txc_q <= txc_d;
      brk_rel_q <= brk_rel_d;
      shr_q <= shr_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      par_en_q <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q <= stop2_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// tb_uart_tx_fifo_ctrl: directed frame table plus multi-cycle corner sequences
module tb_uart_tx_fifo_ctrl;
  logic baud, rst, te, data_valid, data_ready, stop2, send_break, tx, tx_busy, txc;
  logic [8:0] data_in;
  logic [3:0] char_size;
  logic [1:0] parity_mode;
  logic [2:0] fifo_count;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic [8:0] data;
    logic [3:0] cs;
    logic [1:0] pm;
    logic s2;
    int len;
    logic [15:0] bits;
  } vec_t;
  vec_t tbl [7];
  logic [9:0] fr [3];
  uart_tx_fifo_ctrl #(.FIFO_DEPTH(4), .MAX_CHAR(9)) dut (
    .baud(baud), .rst(rst), .te(te), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .char_size(char_size), .parity_mode(parity_mode),
    .stop2(stop2), .send_break(send_break), .tx(tx), .tx_busy(tx_busy), .txc(txc),
    .fifo_count(fifo_count)
  );
  always #5 baud = ~baud;
  task automatic tick;
    @(posedge baud);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cfg(input logic [3:0] cs, input logic [1:0] pm, input logic s2);
    char_size = cs;
    parity_mode = pm;
    stop2 = s2;
  endtask
  initial begin
    tbl[0] = '{9'h0A5, 4'd8, 2'b00, 1'b0, 10, 16'b1101001010};
    tbl[1] = '{9'h055, 4'd8, 2'b01, 1'b0, 11, 16'b10010101010};
    tbl[2] = '{9'h055, 4'd8, 2'b10, 1'b0, 11, 16'b11010101010};
    tbl[3] = '{9'h041, 4'd7, 2'b01, 1'b1, 11, 16'b11010000010};
    tbl[4] = '{9'h0F3, 4'd3, 2'b01, 1'b0, 8, 16'b11100110};
    tbl[5] = '{9'h1A6, 4'd12, 2'b10, 1'b1, 13, 16'b1101101001100};
    tbl[6] = '{9'h02C, 4'd6, 2'b11, 1'b0, 8, 16'b11011000};
    fr[0] = {1'b1, 8'hA5, 1'b0};
    fr[1] = {1'b1, 8'h3C, 1'b0};
    fr[2] = {1'b1, 8'h81, 1'b0};
    baud = 0; rst = 1; te = 1; data_in = '0; data_valid = 0; send_break = 0;
    cfg(4'd8, 2'b00, 1'b0);
    tick; tick;
    chk("rst_tx", tx, 1); chk("rst_busy", tx_busy, 0); chk("rst_txc", txc, 0);
    chk("rst_count", fifo_count, 0); chk("rst_ready", data_ready, 1);
    rst = 0; tick;
    chk("idle_tx", tx, 1);
    for (int v = 0; v < 7; v++) begin
      data_in = tbl[v].data;
      cfg(tbl[v].cs, tbl[v].pm, tbl[v].s2);
      data_valid = 1;
      tick;
      data_valid = 0;
      chk($sformatf("v%0d_pushcnt", v), fifo_count, 1);
      chk($sformatf("v%0d_pretx", v), tx, 1);
      for (int i = 0; i < tbl[v].len; i++) begin
        tick;
        if (i == 0) cfg(4'd5, ~tbl[v].pm, ~tbl[v].s2);
        chk($sformatf("v%0d_bit%0d", v, i), tx, tbl[v].bits[i]);
        chk($sformatf("v%0d_busy%0d", v, i), tx_busy, 1);
        chk($sformatf("v%0d_txc%0d", v, i), txc, 0);
      end
      tick;
      chk($sformatf("v%0d_end_tx", v), tx, 1); chk($sformatf("v%0d_end_busy", v), tx_busy, 0);
      chk($sformatf("v%0d_end_txc", v), txc, 1); chk($sformatf("v%0d_end_cnt", v), fifo_count, 0);
      tick;
      chk($sformatf("v%0d_txc_once", v), txc, 0);
    end
    // three queued words go out as contiguous frames
    cfg(4'd8, 2'b00, 1'b0);
    te = 0; data_valid = 1;
    for (int k = 0; k < 3; k++) begin
      data_in = {1'b0, fr[k][8:1]};
      tick;
      chk($sformatf("b2b_fill%0d", k), fifo_count, k + 1);
    end
    data_valid = 0; te = 1;
    for (int i = 0; i < 30; i++) begin
      tick;
      chk($sformatf("b2b_bit%0d", i), tx, fr[i / 10][i % 10]);
      chk($sformatf("b2b_busy%0d", i), tx_busy, 1);
      chk($sformatf("b2b_txc%0d", i), txc, 0);
      if (i % 10 == 0) chk($sformatf("b2b_cnt%0d", i), fifo_count, 2 - i / 10);
    end
    tick;
    chk("b2b_end_txc", txc, 1); chk("b2b_end_busy", tx_busy, 0);
    tick;
    // fill past capacity with the transmitter disabled
    te = 0; data_valid = 1;
    for (int k = 0; k < 5; k++) begin
      data_in = 9'(k + 1);
      tick;
      chk($sformatf("full_cnt%0d", k), fifo_count, k < 4 ? k + 1 : 4);
      chk($sformatf("full_rdy%0d", k), data_ready, k < 3 ? 1 : 0);
    end
    data_valid = 0; te = 1;
    begin
      int busy_cnt = 0;
      logic seen = 0;
      for (int c = 0; c < 100 && !seen; c++) begin
        tick;
        if (txc) seen = 1;
        else if (tx_busy) busy_cnt++;
      end
      chk("full_txc_seen", seen, 1);
      chk("full_busy_cycles", busy_cnt, 40);
      chk("full_drained", fifo_count, 0);
    end
    tick;
    // te dropped mid-frame: frame completes, queue is retained
    te = 0; data_valid = 1; data_in = 9'h0A5;
    tick; tick;
    data_valid = 0;
    chk("te_fill", fifo_count, 2);
    te = 1;
    tick;
    chk("te_start", tx, 0); chk("te_cnt1", fifo_count, 1);
    tick; tick;
    te = 0;
    repeat (8) tick;
    chk("te_end_busy", tx_busy, 0); chk("te_end_txc", txc, 0);
    chk("te_end_cnt", fifo_count, 1); chk("te_end_tx", tx, 1);
    tick;
    chk("te_hold_busy", tx_busy, 0); chk("te_hold_cnt", fifo_count, 1);
    te = 1;
    tick;
    chk("te_resume_tx", tx, 0); chk("te_resume_cnt", fifo_count, 0);
    repeat (10) tick;
    chk("te_resume_txc", txc, 1);
    tick;
    // push and pop on the same edge leave the count unchanged
    data_valid = 1; data_in = 9'h0A5;
    tick;
    chk("pp_cnt0", fifo_count, 1); chk("pp_idle", tx, 1);
    data_in = 9'h03C;
    tick;
    data_valid = 0;
    chk("pp_cnt1", fifo_count, 1); chk("pp_start", tx, 0);
    repeat (10) tick;
    chk("pp_second_start", tx, 0); chk("pp_second_busy", tx_busy, 1);
    chk("pp_second_cnt", fifo_count, 0); chk("pp_no_txc", txc, 0);
    repeat (10) tick;
    chk("pp_txc", txc, 1);
    tick;
    // break requested mid-frame
    data_valid = 1; data_in = 9'h0A5;
    tick;
    data_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (i == 3) send_break = 1;
      chk($sformatf("brk_bit%0d", i), tx, fr[0][i]);
    end
    tick;
    chk("brk_fend_tx", tx, 1); chk("brk_fend_busy", tx_busy, 0); chk("brk_fend_txc", txc, 1);
    tick;
    chk("brk_start_tx", tx, 0); chk("brk_start_busy", tx_busy, 1); chk("brk_start_txc", txc, 0);
    for (int k = 1; k < 20; k++) begin
      tick;
      chk($sformatf("brk_low%0d", k), tx, 0);
    end
    send_break = 0;
    tick;
    chk("brk_rel_tx", tx, 1); chk("brk_rel_busy", tx_busy, 1);
    tick;
    chk("brk_idle_tx", tx, 1); chk("brk_idle_busy", tx_busy, 0); chk("brk_idle_txc", txc, 0);
    // reset in the middle of the data bits
    data_valid = 1; data_in = 9'h0A5;
    tick; tick;
    data_valid = 0;
    tick; tick; tick;
    chk("rmid_busy_pre", tx_busy, 1);
    rst = 1;
    tick;
    chk("rmid_tx", tx, 1); chk("rmid_cnt", fifo_count, 0);
    chk("rmid_busy", tx_busy, 0); chk("rmid_ready", data_ready, 1);
    rst = 0;
    tick;
    chk("rmid_after_tx", tx, 1); chk("rmid_after_busy", tx_busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
